// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared types, width helpers and address composition for matrix_reader
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mat_state_t;

  localparam int MAT_M_DEF = 8;
  localparam int MAT_N_DEF = 8;

  // Counter width for a range of n values; never below one bit so M=1 or N=1 still builds.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MAT_ROW_W_DEF = cnt_w(MAT_M_DEF);
  localparam int MAT_COL_W_DEF = cnt_w(MAT_N_DEF);

  function automatic int unsigned mat_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mat_skid_fifo.sv
// rtl/mat_skid_fifo.sv - 2-entry skid FIFO holding elements returned by the matrix memory
module mat_skid_fifo
  import mat_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new element lands behind any survivor.
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/matrix_reader.sv
// rtl/matrix_reader.sv - walks the matrix memory and streams every element; MAT_TRANSPOSE_EN selects column-major scan
module matrix_reader
  import mat_pkg::*;
#(
  parameter int DW     = 8,
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int ADDR_W = M + N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              memRamEN,
  output logic              memReadEN,
  output logic              memWriteEN,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DW-1:0]     memData,
  output logic [DW-1:0]     outData,
  output logic              outValid,
  input  logic              outReady,
  output logic              outLast
);

  localparam int ROW_W = cnt_w(M);
  localparam int COL_W = cnt_w(N);
  localparam int TOTAL = M * N;
  localparam int IDX_W = cnt_w(TOTAL);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TOTAL - 1);

  mat_state_t       state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] out_idx;
  logic             inflight;
  logic [1:0]       fifo_count;
  logic [DW-1:0]    fifo_head;
  logic             pop;
  logic             issue;
  logic             last_addr;

  assign outValid  = (fifo_count != 2'd0);
  assign pop       = outValid & outReady;
  assign outData   = fifo_head;
  assign outLast   = outValid && (out_idx == IDX_MAX);
  assign last_addr = (row == ROW_MAX) && (col == COL_MAX);

  // Issue only while the buffered plus in-flight elements, after this cycle's pop, stay below two.
  assign issue = (state == READ) &&
                 (({1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);

  assign memRamEN   = issue;
  assign memReadEN  = issue;
  assign memWriteEN = 1'b0;
  assign memAddr    = ADDR_W'(mat_addr(32'(row), 32'(col), N));

  mat_skid_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (memData),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      out_idx  <= '0;
      inflight <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (pop) out_idx <= out_idx + 1'b1;
      if (issue) begin
`ifdef MAT_TRANSPOSE_EN
        if (row == ROW_MAX) begin
          row <= '0;
          col <= (col == COL_MAX) ? '0 : col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
`else
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
`endif
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (issue && last_addr) state <= DRAIN;
        end
        DRAIN: begin
          if ((pop && outLast) || (fifo_count == 2'd0 && !inflight)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
// tb/tb_matrix_reader.sv - randomized self-checking bench for matrix_reader with a preloaded memory model
module tb_matrix_reader;

`ifdef MAT_TRANSPOSE_EN
  localparam int M = 2;
  localparam int N = 3;
`else
  localparam int M = 4;
  localparam int N = 4;
`endif
  localparam int DW = 8;
  localparam int ADDR_W = M + N;
  localparam int MN = M * N;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              outReady = 1'b1;
  logic              busy, done, memRamEN, memReadEN, memWriteEN, outValid, outLast;
  logic [ADDR_W-1:0] memAddr;
  logic [DW-1:0]     memData = '0;
  logic [DW-1:0]     outData;

  logic [DW-1:0] mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int iss, rx, done_cnt, first_cyc, last_cyc;
  int exp_addr [MN];

  always #5 clk = ~clk;

  matrix_reader #(.DW(DW), .M(M), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .memRamEN   (memRamEN),
    .memReadEN  (memReadEN),
    .memWriteEN (memWriteEN),
    .memAddr    (memAddr),
    .memData    (memData),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .outLast    (outLast)
  );

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DW'(i);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memRamEN && memReadEN) memData <= mem[memAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference order: element k of the stream is memory address exp_addr[k].
  initial begin
    logic stall_prev, last_prev, held_last;
    logic [DW-1:0] held_data;
    int k;
    k = 0;
`ifdef MAT_TRANSPOSE_EN
    for (int c = 0; c < N; c++)
      for (int r = 0; r < M; r++) begin
        exp_addr[k] = r * N + c;
        k++;
      end
`else
    for (int i = 0; i < MN; i++) exp_addr[i] = i;
`endif
    stall_prev = 0; last_prev = 0; held_last = 0; held_data = '0;
    iss = 0; rx = 0; done_cnt = 0; first_cyc = 0; last_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss = 0; rx = 0; done_cnt = 0; stall_prev = 0; last_prev = 0;
      end else begin
        check("wr_en_zero", memWriteEN, 0);
        check("ram_read_pair", memRamEN, memReadEN);
        if (stall_prev) begin
          check("hold_valid", outValid, 1);
          check("hold_data", outData, held_data);
          check("hold_last", outLast, held_last);
        end
        check("done_after_last", done, last_prev);
        if (done) check("busy_at_done", busy, 0);
        if (memReadEN) begin
          if (iss < MN) check("read_addr", memAddr, exp_addr[iss]);
          else check("extra_read", 1, 0);
          iss++;
        end
        if (outValid) begin
          if (rx < MN) check("last_flag", outLast, rx == MN - 1);
          else check("extra_valid", 1, 0);
        end else begin
          check("last_idle", outLast, 0);
        end
        if (outValid && outReady) begin
          if (rx < MN) check("data", outData, exp_addr[rx] & 255);
          if (rx == 0) first_cyc = cyc;
          last_cyc = cyc;
          rx++;
        end
        check("occupancy_le2", (iss - rx) <= 2, 1);
        if (done) done_cnt++;
        last_prev  = outValid && outReady && outLast;
        stall_prev = outValid && !outReady;
        held_data  = outData;
        held_last  = outLast;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, outValid, 0);
    check({tag, "_last"}, outLast, 0);
    check({tag, "_ramen"}, memRamEN, 0);
    check({tag, "_readen"}, memReadEN, 0);
    check({tag, "_data"}, outData, 0);
    check({tag, "_addr"}, memAddr, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // mode: 0 ready high, 1 toggling, 2 random, 3 long stall at element 5
  task automatic run(input int mode, input int poke, input int rst7);
    int  stall_left;
    bit  stalled, did_rst, poked_last;
    stall_left = 0; stalled = 0; did_rst = 0; poked_last = 0;
    outReady = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("lat_busy", busy, 1);
    check("lat_first_read", memReadEN, 1);
    check("lat_valid_k0", outValid, 0);
    @(negedge clk);
    check("lat_valid_k1", outValid, 0);
    @(negedge clk);
    check("lat_valid_k2", outValid, 1);
    for (int n = 0; n < 400 && done_cnt == 0 && !did_rst; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        1: outReady = (n % 2 == 0) ? 1'b0 : 1'b1;
        2: outReady = 1'($urandom_range(0, 1));
        3: begin
          if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) begin
              check("stall_no_read", memReadEN, 0);
              check("stall_data", outData, 5);
              outReady = 1'b1;
            end
          end else if (!stalled && outValid && outData == 5) begin
            stalled = 1;
            stall_left = 10;
            outReady = 1'b0;
          end
        end
        default: outReady = 1'b1;
      endcase
      if (poke != 0) begin
        if (n == 3) start = 1'b1;
        if (!poked_last && outValid && outLast) begin
          start = 1'b1;
          poked_last = 1;
        end
      end
      if (rst7 != 0 && rx == 8) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("rst_mid");
        rst = 1'b0;
        did_rst = 1;
      end
    end
    if (!did_rst) begin
      repeat (5) @(negedge clk);
      check("done_once", done_cnt, 1);
      check("elem_count", rx, MN);
      check("read_count", iss, MN);
      check("busy_idle", busy, 0);
      if (mode == 3) check("stall_seen", stalled, 1);
      if (mode == 0 && poke == 0) check("throughput", last_cyc - first_cyc, MN - 1);
    end
    outReady = 1'b1;
  endtask

  initial begin
    do_reset();
    run(0, 0, 0);
    do_reset();
    run(1, 0, 0);
    do_reset();
    run(3, 0, 0);
    for (int r = 0; r < 3; r++) begin
      do_reset();
      run(2, 0, 0);
    end
    do_reset();
    run(0, 1, 0);
    do_reset();
    run(0, 0, 1);
    run(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
